vend_ctrl_n: RTL and testbench

Parametrised N-product vending controller: the next generation of the team's two-product coffee vending core. It adds programmable product count, credit width and cup quantity, credit saturation with coin echo, and a greedy one-coin-per-cycle change sequencer. The block sits between the coin acceptor and button panel inputs and the brewer handshake (Start/Making/Done/Coffee/TakeOut).

---
 rtl/vend_ctrl_n_if.sv | 43 ++++
 rtl/vend_ctrl_n.sv | 215 +++++++++++++++++++++
 tb/tb_vend_ctrl_n.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/vend_ctrl_n_if.sv
// Panel/brewer-side signal bundle for vend_ctrl_n: coin acceptor, buttons,
// brewer handshake and coin-out pulses. The controller uses the slave modport.
interface vend_ctrl_n_if #(
    parameter int NPROD = 2,
    parameter int CW    = 7,
    parameter int PW    = 7
);
    logic                  Manage;
    logic                  Confirm;
    logic [NPROD*PW-1:0]   Price_in;
    logic                  Coin50;
    logic                  Coin100;
    logic                  Coin500;
    logic                  Coin1000;
    logic [NPROD-1:0]      Select;
    logic [2:0]            Cups;
    logic                  Start;
    logic                  Done;
    logic                  TakeOut;
    logic                  Return;
    logic                  Return50;
    logic                  Return100;
    logic                  Return500;
    logic                  Return1000;
    logic                  Making;
    logic                  Coffee;
    logic                  Reject;
    logic [CW-1:0]         Sum;

    modport master (
        output Manage, Confirm, Price_in, Coin50, Coin100, Coin500, Coin1000,
               Select, Cups, Start, Done, TakeOut, Return,
        input  Return50, Return100, Return500, Return1000, Making, Coffee,
               Reject, Sum
    );

    modport slave (
        input  Manage, Confirm, Price_in, Coin50, Coin100, Coin500, Coin1000,
               Select, Cups, Start, Done, TakeOut, Return,
        output Return50, Return100, Return500, Return1000, Making, Coffee,
               Reject, Sum
    );
endinterface

// File: rtl/vend_ctrl_n.sv
// N-product vending controller with saturating credit, coin echo and greedy change.
// Optional: define VEND_AUTO_CHANGE_EN to return residual credit after TakeOut.
module vend_ctrl_n #(
    parameter int NPROD = 2,
    parameter int CW    = 7,
    parameter int PW    = 7
) (
    input  logic          CLK,
    input  logic          RST_N,
    vend_ctrl_n_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CREDIT, S_MANAGE, S_ORDER, S_MAKING, S_SERVE, S_CHANGE
    } state_t;

    localparam logic [31:0] SUM_MAX = 32'((64'd1 << CW) - 64'd1);

    state_t          state_q, state_d;
    logic [CW-1:0]   sum_q, sum_d;
    logic [PW+2:0]   cost_q, cost_d;
    logic            making_q, making_d;
    logic            coffee_q, coffee_d;
    logic            reject_q, reject_d;
    logic [3:0]      ret_q, ret_d;
    logic [PW-1:0]   price_q [NPROD];
    logic            price_load;

    logic [3:0]      coin_v;
    logic [3:0]      accept_v;
    logic [3:0]      chg_v;
    logic            acc_any;
    logic [1:0]      acc_idx;
    logic [31:0]     sum_w;
    logic [31:0]     sum_plus;
    logic            acc_fits;
    logic [1:0]      chg_idx;
    logic [31:0]     chg_left;
    logic [PW-1:0]   price_sel;
    logic [PW+2:0]   cost_c;
    logic            sel_valid;
    logic            sel_ok;

    // Coin values in 50-unit steps, indexed 50/100/500/1000.
    function automatic logic [31:0] coin_val(input logic [1:0] idx);
        case (idx)
            2'd0:    return 32'd1;
            2'd1:    return 32'd2;
            2'd2:    return 32'd10;
            default: return 32'd20;
        endcase
    endfunction

    assign coin_v = {bus.Coin1000, bus.Coin500, bus.Coin100, bus.Coin50};
    assign sum_w  = 32'(sum_q);

    always_comb begin
        acc_any = 1'b0;
        acc_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (coin_v[i]) begin
                acc_any = 1'b1;
                acc_idx = 2'(i);
            end
        end
    end

    assign sum_plus = sum_w + coin_val(acc_idx);
    assign acc_fits = acc_any && (sum_plus <= SUM_MAX);

    always_comb begin
        if (sum_w >= 32'd20)      chg_idx = 2'd3;
        else if (sum_w >= 32'd10) chg_idx = 2'd2;
        else if (sum_w >= 32'd2)  chg_idx = 2'd1;
        else                      chg_idx = 2'd0;
    end

    assign chg_left = sum_w - coin_val(chg_idx);

    always_comb begin
        price_sel = '0;
        for (int i = 0; i < NPROD; i++) begin
            if (bus.Select[i]) price_sel = price_sel | price_q[i];
        end
    end

    assign cost_c    = (PW+3)'(price_sel) * (PW+3)'(bus.Cups);
    assign sel_valid = $onehot(bus.Select) && (bus.Cups != 3'd0) && (bus.Cups <= 3'd5);
    assign sel_ok    = sel_valid && (cost_c != '0) && (32'(cost_c) <= sum_w);

    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        cost_d     = cost_q;
        making_d   = making_q;
        coffee_d   = coffee_q;
        reject_d   = 1'b0;
        accept_v   = 4'b0000;
        chg_v      = 4'b0000;
        price_load = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.Manage) begin
                    state_d = S_MANAGE;
                end else if (acc_fits) begin
                    accept_v[acc_idx] = 1'b1;
                    sum_d   = CW'(sum_plus);
                    state_d = S_CREDIT;
                end
            end
            S_MANAGE: begin
                if (bus.Confirm) begin
                    price_load = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_CREDIT, S_ORDER: begin
                // Return outranks Select, which outranks coins and Start.
                if (bus.Return) begin
                    state_d = S_CHANGE;
                end else if (bus.Select != '0) begin
                    if (sel_ok) begin
                        cost_d  = cost_c;
                        state_d = S_ORDER;
                    end else begin
                        reject_d = 1'b1;
                        state_d  = S_CREDIT;
                    end
                end else if (state_q == S_ORDER) begin
                    if (bus.Start) begin
                        sum_d    = CW'(sum_w - 32'(cost_q));
                        making_d = 1'b1;
                        state_d  = S_MAKING;
                    end
                end else if (acc_fits) begin
                    accept_v[acc_idx] = 1'b1;
                    sum_d = CW'(sum_plus);
                end
            end
            S_MAKING: begin
                if (bus.Done) begin
                    making_d = 1'b0;
                    coffee_d = 1'b1;
                    state_d  = S_SERVE;
                end
            end
            S_SERVE: begin
                if (bus.TakeOut) begin
                    coffee_d = 1'b0;
                    if (sum_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
`ifdef VEND_AUTO_CHANGE_EN
                        state_d = S_CHANGE;
`else
                        state_d = S_CREDIT;
`endif
                    end
                end
            end
            S_CHANGE: begin
                // An echo on the same coin output takes the slot; change waits a cycle.
                if (sum_q == '0) begin
                    state_d = S_IDLE;
                end else if (!coin_v[chg_idx]) begin
                    chg_v[chg_idx] = 1'b1;
                    sum_d = CW'(chg_left);
                    if (chg_left == 32'd0) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ret_d = (coin_v & ~accept_v) | chg_v;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            sum_q    <= '0;
            cost_q   <= '0;
            making_q <= 1'b0;
            coffee_q <= 1'b0;
            reject_q <= 1'b0;
            ret_q    <= 4'b0000;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            cost_q   <= cost_d;
            making_q <= making_d;
            coffee_q <= coffee_d;
            reject_q <= reject_d;
            ret_q    <= ret_d;
        end
    end

    for (genvar gi = 0; gi < NPROD; gi++) begin : g_price
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                price_q[gi] <= '0;
            end else if (price_load) begin
                price_q[gi] <= bus.Price_in[gi*PW +: PW];
            end
        end
    end

    assign bus.Return50   = ret_q[0];
    assign bus.Return100  = ret_q[1];
    assign bus.Return500  = ret_q[2];
    assign bus.Return1000 = ret_q[3];
    assign bus.Making     = making_q;
    assign bus.Coffee     = coffee_q;
    assign bus.Reject     = reject_q;
    assign bus.Sum        = sum_q;
endmodule

// File: tb/tb_vend_ctrl_n.sv
// Directed bench for vend_ctrl_n: pulse outputs are checked by a scoreboard
// monitor, level outputs (Sum/Making/Coffee) by the stimulus process.
module tb_vend_ctrl_n;
    localparam int NPROD = 2;
    localparam int CW    = 7;
    localparam int PW    = 7;

    localparam logic [4:0] E50  = 5'b00001;
    localparam logic [4:0] E100 = 5'b00010;
    localparam logic [4:0] E500 = 5'b00100;
    localparam logic [4:0] E1K  = 5'b01000;
    localparam logic [4:0] EREJ = 5'b10000;

    logic CLK = 1'b0;
    logic RST_N;
    int   vectors = 0;
    int   miscompares = 0;
    logic [4:0] exp_q [$];

    vend_ctrl_n_if #(.NPROD(NPROD), .CW(CW), .PW(PW)) bus ();

    vend_ctrl_n #(.NPROD(NPROD), .CW(CW), .PW(PW)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Monitor: every cycle showing a pulse output consumes one expected entry.
    always @(negedge CLK) begin
        logic [4:0] act;
        logic [4:0] exp;
        act = {bus.Reject, bus.Return1000, bus.Return500, bus.Return100, bus.Return50};
        if (RST_N === 1'b1 && act != 5'b00000) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pulse @%0t: got %05b, expected none", $time, act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    miscompares++;
                    $display("FAIL pulse @%0t: got %05b, expected %05b", $time, act, exp);
                end else begin
                    $display("pulse @%0t: %05b ok", $time, act);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end else begin
            $display("check %s @%0t: %0d ok", name, $time, act);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        bus.Manage   = 1'b0;
        bus.Confirm  = 1'b0;
        bus.Coin50   = 1'b0;
        bus.Coin100  = 1'b0;
        bus.Coin500  = 1'b0;
        bus.Coin1000 = 1'b0;
        bus.Select   = '0;
        bus.Cups     = 3'd0;
        bus.Start    = 1'b0;
        bus.Done     = 1'b0;
        bus.TakeOut  = 1'b0;
        bus.Return   = 1'b0;
    endtask

    // v = {1000, 500, 100, 50}
    task automatic drop(input logic [3:0] v);
        {bus.Coin1000, bus.Coin500, bus.Coin100, bus.Coin50} = v;
        step();
        clr();
    endtask

    task automatic select(input logic [NPROD-1:0] s, input logic [2:0] c);
        bus.Select = s;
        bus.Cups   = c;
        step();
        clr();
    endtask

    task automatic sum_is(input string name, input int v);
        @(negedge CLK);
        check(name, 32'(bus.Sum), 32'(v));
    endtask

    initial begin
        clr();
        bus.Price_in = '0;
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_sum", 32'(bus.Sum), 0);
        check("rst_making", 32'(bus.Making), 0);
        check("rst_coffee", 32'(bus.Coffee), 0);
        check("rst_pulses", 32'({bus.Reject, bus.Return1000, bus.Return500, bus.Return100, bus.Return50}), 0);
        RST_N = 1'b1;
        step();

        // Program p0=4, p1=6
        bus.Manage = 1'b1; step(); clr();
        bus.Price_in = {7'd6, 7'd4};
        bus.Confirm = 1'b1; step(); clr();

        // Purchase p0 x1 with 3 x Coin100
        for (int i = 1; i <= 3; i++) begin
            drop(4'b0010);
            sum_is("buy_credit", 2 * i);
        end
        select(2'b01, 3'd1);
        bus.Start = 1'b1; step(); clr();
        @(negedge CLK);
        check("buy_start_sum", 32'(bus.Sum), 2);
        check("buy_making", 32'(bus.Making), 1);
        bus.Done = 1'b1; step(); clr();
        @(negedge CLK);
        check("buy_done_making", 32'(bus.Making), 0);
        check("buy_coffee", 32'(bus.Coffee), 1);
`ifdef VEND_AUTO_CHANGE_EN
        exp_q.push_back(E100);
        bus.TakeOut = 1'b1; step(); clr();
        @(negedge CLK);
        check("take_coffee", 32'(bus.Coffee), 0);
        check("take_sum", 32'(bus.Sum), 2);
        step();
        sum_is("auto_change_sum", 0);
`else
        bus.TakeOut = 1'b1; step(); clr();
        @(negedge CLK);
        check("take_coffee", 32'(bus.Coffee), 0);
        check("take_sum", 32'(bus.Sum), 2);
        exp_q.push_back(EREJ);
        select(2'b01, 3'd1);
        exp_q.push_back(E100);
        bus.Return = 1'b1; step(); clr();
        step();
        sum_is("manual_change_sum", 0);
`endif

        // Greedy change from 37
        drop(4'b1000); drop(4'b0100); drop(4'b0010); drop(4'b0010); drop(4'b0010); drop(4'b0001);
        sum_is("chg_credit", 37);
        exp_q.push_back(E1K); exp_q.push_back(E500); exp_q.push_back(E100);
        exp_q.push_back(E100); exp_q.push_back(E100); exp_q.push_back(E50);
        bus.Return = 1'b1; step(); clr();
        repeat (3) step();
        sum_is("chg_mid", 5);
        repeat (3) step();
        sum_is("chg_end", 0);

        // Saturation at 120 + 20 > 127
        repeat (6) drop(4'b1000);
        sum_is("sat_credit", 120);
        exp_q.push_back(E1K);
        drop(4'b1000);
        sum_is("sat_hold", 120);
        for (int i = 0; i < 6; i++) exp_q.push_back(E1K);
        bus.Return = 1'b1; step(); clr();
        repeat (6) step();
        sum_is("sat_drain", 0);
        exp_q.push_back(E500);
        drop(4'b0101);
        sum_is("dual_coin", 1);

        // Reject cases, then boundary cost == Sum accepted
        drop(4'b0010); drop(4'b0010); drop(4'b0001);
        sum_is("rej_credit", 6);
        exp_q.push_back(EREJ);
        select(2'b10, 3'd5);
        exp_q.push_back(EREJ);
        select(2'b11, 3'd1);
        exp_q.push_back(EREJ);
        select(2'b01, 3'd0);
        sum_is("rej_sum", 6);
        select(2'b10, 3'd1);
        bus.Start = 1'b1; step(); clr();
        @(negedge CLK);
        check("exact_sum", 32'(bus.Sum), 0);
        check("exact_making", 32'(bus.Making), 1);

        // Asynchronous reset mid-MAKING
        RST_N = 1'b0;
        #1;
        check("arst_making", 32'(bus.Making), 0);
        check("arst_coffee", 32'(bus.Coffee), 0);
        check("arst_sum", 32'(bus.Sum), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        step();

        // Prices cleared -> cost 0 rejected; Return beats coin; echo stalls change
        drop(4'b0010);
        sum_is("post_rst_credit", 2);
        exp_q.push_back(EREJ);
        select(2'b01, 3'd1);
        exp_q.push_back(E50); exp_q.push_back(E100); exp_q.push_back(E100);
        bus.Return = 1'b1; bus.Coin50 = 1'b1; step(); clr();
        bus.Coin100 = 1'b1; step(); clr();
        sum_is("stall_sum", 2);
        step();
        sum_is("stall_done", 0);
        repeat (3) step();

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
